// File: rtl/board_ctrl_pkg.sv
// board_ctrl_pkg: display mode encodings and width helper shared by the board front-end
package board_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_STATUS = 2'd0,
    MODE_RESULT = 2'd1,
    MODE_HEART  = 2'd2,
    MODE_BAD    = 2'd3
  } mode_t;
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser chain, counter debounce and registered rise pulse for one button
module btn_debounce
  import board_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 125000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);
  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync, flip;
  assign sync = sync_q[SYNC_STAGES-1];
  assign flip = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      cnt    <= (sync == level || flip) ? '0 : cnt + 1'b1;
      level  <= flip ? sync : level;
      rise   <= flip & sync;
    end
  end
endmodule

// File: rtl/board_ctrl_panel.sv
// board_ctrl_panel: debounced buttons, mode FSM and paged LED display engine
module board_ctrl_panel
  import board_ctrl_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int MODE_BTN        = 3,
  parameter int N_MACS          = 4,
  parameter int ACC_W           = 16,
  parameter int N_LED           = 4,
  parameter int PAGE_CYCLES     = 62500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        btn_in,
  output logic [N_BTN-1:0]        btn_level,
  output logic [N_BTN-1:0]        btn_rise,
  input  logic                    busy,
  input  logic [N_MACS-1:0]       valid_in,
  input  logic [N_MACS*ACC_W-1:0] acc_flat,
  output logic [1:0]              mode,
  output logic [N_LED-1:0]        led
);
  localparam int SLICES = ACC_W / N_LED;
  localparam int PW     = clog2_min1(PAGE_CYCLES);
  localparam int CHW    = clog2_min1(N_MACS);
  localparam int SW     = clog2_min1(SLICES);
  mode_t mode_q, mode_d;
  logic [PW-1:0] page_cnt;
  logic [CHW-1:0] ch, next_ch;
  logic [SW-1:0] slice;
  logic heart, page_tick, mode_chg, last_slice;
  logic [N_LED-1:0] led_d;
  logic [N_LED+N_MACS-1:0] vext;
  logic unused_vext;
  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in[i]),
        .level (btn_level[i]),
        .rise  (btn_rise[i])
      );
    end
  endgenerate
  assign mode        = mode_q;
  assign page_tick   = page_cnt == PW'(PAGE_CYCLES - 1);
  assign last_slice  = slice == SW'(SLICES - 1);
  assign next_ch     = (ch == CHW'(N_MACS - 1)) ? '0 : ch + 1'b1;
  assign vext        = {{N_LED{1'b0}}, valid_in};
  assign unused_vext = ^vext;
  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_BAD)
      mode_d = MODE_STATUS;
    else if (btn_rise[MODE_BTN])
      mode_d = (mode_q == MODE_STATUS) ? MODE_RESULT :
               (mode_q == MODE_RESULT) ? MODE_HEART : MODE_STATUS;
    mode_chg = mode_d != mode_q;
    led_d = (mode_q == MODE_RESULT) ? acc_flat[ch*ACC_W + slice*N_LED +: N_LED] :
            (mode_q == MODE_HEART)  ? {(N_LED-1)'(ch), heart} :
                                      {busy, vext[N_LED-2:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_STATUS;
      page_cnt <= '0;
      ch       <= '0;
      slice    <= '0;
      heart    <= 1'b0;
      led      <= '0;
    end else begin
      mode_q <= mode_d;
      led    <= led_d;
      if (mode_chg) begin
        page_cnt <= '0;
        ch       <= '0;
        slice    <= '0;
        heart    <= 1'b0;
      end else begin
        page_cnt <= page_tick ? '0 : page_cnt + 1'b1;
        if (page_tick && mode_q == MODE_RESULT) begin
          slice <= last_slice ? '0 : slice + 1'b1;
          if (last_slice) ch <= next_ch;
        end
        if (page_tick && mode_q == MODE_HEART) begin
          heart <= ~heart;
          if (heart) ch <= next_ch;
        end
      end
    end
  end
endmodule

// File: tb/tb_board_ctrl_panel.sv
// tb_board_ctrl_panel: directed checks of debounce, mode cycling and LED display engines
module tb_board_ctrl_panel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level, btn_rise;
  logic busy = 1'b0;
  logic [1:0] valid_in = '0;
  logic [15:0] acc_flat = '0;
  logic [1:0] mode;
  logic [3:0] led;
  int n_vec = 0;
  int n_bad = 0;
  board_ctrl_panel #(
    .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .MODE_BTN(3),
    .N_MACS(2), .ACC_W(8), .N_LED(4), .PAGE_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .btn_rise(btn_rise),
    .busy(busy), .valid_in(valid_in), .acc_flat(acc_flat), .mode(mode), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] b, input logic [1:0] m_exp);
    btn_in = b;
    tick(6);
    chk("press_rise", 32'(btn_rise), 32'(b));
    btn_in = '0;
    tick(1);
    chk("press_mode", 32'(mode), 32'(m_exp));
  endtask
  initial begin
    tick(3);
    chk("rst_led", 32'(led), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_rise", 32'(btn_rise), 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_rise", 32'(btn_rise), 0);
    btn_in[0] = 1'b1;
    tick(5);
    chk("s1_level_early", 32'(btn_level[0]), 0);
    chk("s1_rise_early", 32'(btn_rise[0]), 0);
    tick(1);
    chk("s1_level", 32'(btn_level), 32'h1);
    chk("s1_rise", 32'(btn_rise), 32'h1);
    tick(1);
    chk("s1_rise_once", 32'(btn_rise[0]), 0);
    chk("s1_level_hold", 32'(btn_level[0]), 1);
    btn_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("s1_no_release_pulse", 32'(btn_rise[0]), 0);
    end
    chk("s1_level_released", 32'(btn_level[0]), 0);
    btn_in[1] = 1'b1;
    tick(3);
    btn_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("s2_glitch_level", 32'(btn_level[1]), 0);
      chk("s2_glitch_rise", 32'(btn_rise[1]), 0);
    end
    busy = 1'b1;
    valid_in = 2'b10;
    tick(1);
    chk("s3_status_busy", 32'(led), 32'hA);
    busy = 1'b0;
    valid_in = 2'b00;
    tick(1);
    chk("s3_status_idle", 32'(led), 0);
    acc_flat = {8'hC3, 8'h5A};
    press(4'b1000, 2'd1);
    tick(1);
    chk("s4_led_a", 32'(led), 32'hA);
    tick(7);
    chk("s4_led_a_end", 32'(led), 32'hA);
    tick(1);
    chk("s4_led_5", 32'(led), 32'h5);
    tick(8);
    chk("s4_led_3", 32'(led), 32'h3);
    tick(8);
    chk("s4_led_c", 32'(led), 32'hC);
    tick(8);
    chk("s4_led_wrap", 32'(led), 32'hA);
    press(4'b1001, 2'd2);
    tick(1);
    chk("s5_heart_0", 32'(led), 32'h0);
    tick(7);
    chk("s5_heart_0_end", 32'(led), 32'h0);
    tick(1);
    chk("s5_heart_1", 32'(led), 32'h1);
    tick(8);
    chk("s5_heart_2", 32'(led), 32'h2);
    tick(8);
    chk("s5_heart_3", 32'(led), 32'h3);
    tick(8);
    chk("s5_heart_wrap", 32'(led), 32'h0);
    press(4'b1000, 2'd0);
    busy = 1'b1;
    valid_in = 2'b11;
    tick(1);
    chk("s5_status_back", 32'(led), 32'hB);
    busy = 1'b0;
    valid_in = 2'b00;
    tick(8);
    press(4'b1000, 2'd1);
    tick(1);
    chk("s6_led_a", 32'(led), 32'hA);
    tick(8);
    chk("s6_led_5", 32'(led), 32'h5);
    chk("s6_slice1", 32'(dut.slice), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s6_mode", 32'(mode), 0);
    chk("s6_led", 32'(led), 0);
    chk("s6_page", 32'(dut.page_cnt), 0);
    chk("s6_slice", 32'(dut.slice), 0);
    chk("s6_ch", 32'(dut.ch), 0);
    chk("s6_level", 32'(btn_level), 0);
    tick(1);
    chk("s6_led_after", 32'(led), 0);
    chk("s6_mode_after", 32'(mode), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
